pass_request: RTL and testbench
===============================

PASS_REQUEST -- requirements
Module: pass_request

Interface
REQ-001 SHALL have parameter DEB_LEN, default 16: consecutive cycles the synchronized button must stay high before a press is accepted (range 2..255).
REQ-002 SHALL have parameter COOLDOWN_LEN, default 1024: cycles new presses are ignored after a grant (range 1..4095).
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port btn, input, 1 bit: raw pedestrian button, asynchronous to clk, may bounce.
REQ-006 SHALL have ports R, G, Y, each input, 1 bit: lamp outputs fed back from the downstream traffic-light controller.
REQ-007 SHALL have port pass, output, 1 bit: registered request level driven to the traffic-light controller's pass input.
REQ-008 SHALL have port busy, output, 1 bit: high in PENDING or COOLDOWN.

Function
REQ-009 SHALL pass btn through a 2-flop synchronizer; only its second-stage output is used.
REQ-010 SHALL use an 8-bit debounce counter: increment (saturate at DEB_LEN) while the synchronized button is 1, clear to 0 when it is 0.
REQ-011 SHALL generate a one-cycle press event on the cycle the debounce counter first reaches DEB_LEN; held buttons SHALL produce no further events until released (counter cleared) and re-pressed.
REQ-012 SHALL implement states IDLE, PENDING, COOLDOWN, encoded in 2 bits.
REQ-013 SHALL go IDLE -> PENDING on a press event; press events in PENDING or COOLDOWN are discarded, not queued.
REQ-014 SHALL assert pass = 1 for every cycle in PENDING, and pass = 0 in IDLE and COOLDOWN.
REQ-015 SHALL keep a 1-bit last_stop register, set when R = 1 or Y = 1, cleared on grant.
REQ-016 SHALL detect a grant as a G rising edge (G = 1 this cycle, G = 0 last cycle) while last_stop = 1; blink toggles of G with no preceding R/Y are not grants.
REQ-017 SHALL leave PENDING on a grant: go to COOLDOWN (or IDLE, see REQ-023); pass deasserts on the next clock edge.
REQ-018 SHALL, in COOLDOWN, count a 12-bit counter from 0 and return to IDLE on the cycle it equals COOLDOWN_LEN-1; the counter is cleared on COOLDOWN entry.
REQ-019 SHALL give grant priority over a simultaneous press event: the press is discarded.
REQ-020 SHALL treat illegal state encoding 2'b11 as IDLE on the next clock.

Reset
REQ-021 SHALL, while rst = 1, force state IDLE, pass = 0, busy = 0, and clear synchronizer flops, debounce counter, cooldown counter, last_stop, and the G history flop to 0.
REQ-022 SHALL, on rst assertion mid-PENDING or mid-COOLDOWN, drop pending requests without a grant; the button must be released and re-pressed after reset.

Configuration
REQ-023 SHALL honour macro PASS_COOLDOWN_EN: when defined, COOLDOWN and its counter exist per REQ-018; when undefined, grant goes PENDING -> IDLE directly, no cooldown counter is built, and busy equals pass.

Verification
REQ-024 SHALL pass test 1: btn bounces 0/1 every 3 cycles for 40 cycles, then stays 0 -> no press event, pass stays 0.
REQ-025 SHALL pass test 2: btn held 1 for 30 cycles, DEB_LEN = 16 -> pass rises 19 cycles after btn rises (2 sync + 16 debounce + 1 register), then stays 1.
REQ-026 SHALL pass test 3: in PENDING, drive G 1->0->1 (blink) without R/Y -> pass stays 1; then R = 1 for 5 cycles, then G = 1 -> pass = 0 one cycle after the G edge, busy = 1.
REQ-027 SHALL pass test 4: with PASS_COOLDOWN_EN and COOLDOWN_LEN = 8, press again 3 cycles after grant -> ignored; busy falls exactly 8 cycles after COOLDOWN entry.
REQ-028 SHALL pass test 5: assert rst for 1 cycle while PENDING with btn still held -> pass = 0 immediately; no new request until btn goes 0 and is pressed again.
REQ-029 SHALL pass test 6: without PASS_COOLDOWN_EN, press, grant, press again 2 cycles later -> second request is accepted, with pass rising 19 cycles after the new press.

Source files
------------

// File: rtl/pass_request.sv
`default_nettype none
// ============================================================================
//  Module      : pass_request
//  Description : Pedestrian pass-request generator. It synchronizes and
//                debounces a raw button, raises a registered "pass" request
//                to the downstream traffic-light controller, and drops the
//                request once that controller grants. A grant is a green
//                rising edge that follows a red or yellow phase. An optional
//                cooldown window ignores new presses after a grant.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEB_LEN       number of consecutive synchronized-high cycles needed
//                  before a press is accepted (2..255)
//    COOLDOWN_LEN  number of cycles presses are ignored after a grant
//                  (1..4095); only used when PASS_COOLDOWN_EN is defined
//  Ports
//    clk   in   system clock, rising edge
//    rst   in   asynchronous active-high reset
//    btn   in   raw pedestrian button (asynchronous, may bounce)
//    R     in   red lamp fed back from the traffic-light controller
//    G     in   green lamp fed back from the traffic-light controller
//    Y     in   yellow lamp fed back from the traffic-light controller
//    pass  out  registered request level, high for the whole PENDING state
//    busy  out  registered, high in PENDING or COOLDOWN
//  Configuration macro
//    PASS_COOLDOWN_EN  when defined, builds the COOLDOWN state and its 12-bit
//                      counter. When undefined, a grant returns straight to
//                      IDLE and busy equals pass.
// ============================================================================
module pass_request #(
    parameter int DEB_LEN      = 16,
    parameter int COOLDOWN_LEN = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic R,
    input  logic G,
    input  logic Y,
    output logic pass,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_PENDING  = 2'b01,
        ST_COOLDOWN = 2'b10
    } state_t;

    localparam logic [7:0] c_DEB_MAX = 8'(DEB_LEN);

    state_t     r_state;
    logic       r_sync1;
    logic       r_sync2;
    logic [7:0] r_deb_cnt;
    logic       r_deb_full_d;
    logic [1:0] r_sync_valid;
    logic       r_lock;
    logic       r_last_stop;
    logic       r_g_d;

`ifdef PASS_COOLDOWN_EN
    localparam logic [11:0] c_CD_LAST = 12'(COOLDOWN_LEN - 1);
    logic [11:0] r_cd_cnt;
`endif

    logic w_deb_full;
    logic w_press;
    logic w_grant;

    // The press event fires only on the first cycle the saturated counter
    // reads full, so a held button yields exactly one event.
    assign w_deb_full = (r_deb_cnt == c_DEB_MAX);
    assign w_press    = w_deb_full && !r_deb_full_d && !r_lock;
    // A green rising edge only counts after a red/yellow phase; a blinking
    // green with no stop phase in between is ignored.
    assign w_grant    = G && !r_g_d && r_last_stop;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce counter, saturating at DEB_LEN, cleared on any low sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_cnt    <= 8'd0;
            r_deb_full_d <= 1'b0;
        end else begin
            r_deb_full_d <= w_deb_full;
            if (!r_sync2) begin
                r_deb_cnt <= 8'd0;
            end else if (!w_deb_full) begin
                r_deb_cnt <= r_deb_cnt + 8'd1;
            end
        end
    end

    // Post-reset lockout: a button still held through reset must be released
    // before it can request again. The synchronizer is zeroed by reset, so its
    // output is trusted only once two fresh samples have flowed through it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_valid <= 2'b00;
            r_lock       <= 1'b1;
        end else begin
            r_sync_valid <= {r_sync_valid[0], 1'b1};
            if (r_sync_valid[1] && !r_sync2) begin
                r_lock <= 1'b0;
            end
        end
    end

    // Lamp history: last_stop remembers a red/yellow phase until a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_stop <= 1'b0;
            r_g_d       <= 1'b0;
        end else begin
            r_g_d <= G;
            if (w_grant) begin
                r_last_stop <= 1'b0;
            end else if (R || Y) begin
                r_last_stop <= 1'b1;
            end
        end
    end

    // Request FSM with registered pass/busy outputs. Presses arriving outside
    // IDLE are dropped rather than queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            pass    <= 1'b0;
            busy    <= 1'b0;
`ifdef PASS_COOLDOWN_EN
            r_cd_cnt <= 12'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    pass <= 1'b0;
                    busy <= 1'b0;
                    if (w_press) begin
                        r_state <= ST_PENDING;
                        pass    <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    pass <= 1'b1;
                    busy <= 1'b1;
                    if (w_grant) begin
`ifdef PASS_COOLDOWN_EN
                        r_state  <= ST_COOLDOWN;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        r_cd_cnt <= 12'd0;
`else
                        r_state <= ST_IDLE;
                        pass    <= 1'b0;
                        busy    <= 1'b0;
`endif
                    end
                end
`ifdef PASS_COOLDOWN_EN
                ST_COOLDOWN: begin
                    pass <= 1'b0;
                    busy <= 1'b1;
                    if (r_cd_cnt == c_CD_LAST) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_cd_cnt <= r_cd_cnt + 12'd1;
                    end
                end
`endif
                // Illegal encodings (and COOLDOWN when it is not built)
                // recover to IDLE.
                default: begin
                    r_state <= ST_IDLE;
                    pass    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pass_request.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pass_request
//  Description : Self-checking bench for pass_request. A behavioural model
//                tracks the synchronized button as a run length of high
//                samples, the request phase and the remaining cooldown time;
//                outputs are compared on every falling clock edge. Directed
//                scenarios pin the model with literal expectations, followed
//                by randomized button/lamp/reset activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pass_request;

    localparam int DEB = 16;
    localparam int CD  = 8;

`ifdef PASS_COOLDOWN_EN
    localparam bit HAS_CD = 1'b1;
`else
    localparam bit HAS_CD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic R   = 1'b0;
    logic G   = 1'b0;
    logic Y   = 1'b0;
    logic pass;
    logic busy;

    int total = 0;
    int bad   = 0;

    pass_request #(
        .DEB_LEN      (DEB),
        .COOLDOWN_LEN (CD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .R    (R),
        .G    (G),
        .Y    (Y),
        .pass (pass),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_phase: 0 idle, 1 waiting for grant, 2 cooldown
    int m_s1 = 0, m_s2 = 0;
    int m_run = 0;          // consecutive cycles the synchronized button was high
    int m_lock = 1;         // set by reset until the button is seen released
    int m_since = 0;        // clock edges since reset released
    int m_phase = 0;
    int m_cd_left = 0;
    int m_stop = 0;
    int m_gprev = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_run = 0; m_lock = 1; m_since = 0;
            m_phase = 0; m_cd_left = 0; m_stop = 0; m_gprev = 0;
        end else begin
            bit press, grant;
            press = (m_run == DEB) && (m_lock == 0);
            grant = G && (m_gprev == 0) && (m_stop == 1);
            if (m_phase == 0) begin
                if (press) m_phase = 1;
            end else if (m_phase == 1) begin
                if (grant) begin
                    if (HAS_CD) begin
                        m_phase = 2;
                        m_cd_left = CD;
                    end else begin
                        m_phase = 0;
                    end
                end
            end else begin
                m_cd_left = m_cd_left - 1;
                if (m_cd_left == 0) m_phase = 0;
            end
            if (m_since >= 2 && m_s2 == 0) m_lock = 0;
            if (m_s2 == 1) m_run = (m_run > DEB) ? m_run : m_run + 1;
            else           m_run = 0;
            m_s2 = m_s1;
            m_s1 = int'(btn);
            if (m_since < 10) m_since++;
            if (grant) m_stop = 0;
            else if (R || Y) m_stop = 1;
            m_gprev = int'(G);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic ep, eb;
        ep = !rst && (m_phase == 1);
        eb = !rst && (m_phase != 0);
        check("pass_model", pass, ep);
        check("busy_model", busy, eb);
    end

    // Advance n clock edges; leaves time at edge+2 for checks and driving.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int hold = 0;

    initial begin
        // Reset state
        cyc(2);
        check("reset_pass", pass, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        cyc(5);

        // Test 1: bouncing button never reaches the debounce threshold
        for (int i = 0; i < 40; i++) begin
            btn = ((i / 3) % 2) == 1;
            cyc(1);
        end
        btn = 1'b0;
        cyc(25);
        check("bounce_no_pass", pass, 1'b0);

        // Test 2: held button, pass rises exactly 19 cycles after btn rises
        btn = 1'b1;
        cyc(18);
        check("press_t18", pass, 1'b0);
        cyc(1);
        check("press_t19", pass, 1'b1);
        cyc(11);
        check("press_held", pass, 1'b1);
        btn = 1'b0;
        cyc(3);

        // Test 3: green blink without stop phase is not a grant
        G = 1'b1; cyc(2);
        G = 1'b0; cyc(2);
        G = 1'b1; cyc(2);
        G = 1'b0; cyc(1);
        check("blink_no_grant", pass, 1'b1);

        // Test 3/4: real grant, with a press event landing 3 cycles after it
        btn = 1'b1;            // press event would act 19 edges from here
        cyc(10);
        R = 1'b1; cyc(5);
        R = 1'b0; G = 1'b1;    // grant acts on the 16th edge
        cyc(1);
        check("grant_pass", pass, 1'b0);
        check("grant_busy", busy, HAS_CD);
        G = 1'b0;
        cyc(7);
        check("cd_busy_last", busy, 1'b1);
        cyc(1);
        check("cd_busy_end", busy, !HAS_CD);
        check("cd_press_drop", pass, !HAS_CD);
        btn = 1'b0;
        cyc(4);

        // Test 5: reset mid-request with button held
        btn = 1'b1;
        cyc(19);
        check("pre_rst_pass", pass, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_pass", pass, 1'b0);
        check("rst_async_busy", busy, 1'b0);
        cyc(1);
        rst = 1'b0;
        cyc(30);
        check("rst_held_no_pass", pass, 1'b0);
        btn = 1'b0;
        cyc(5);
        btn = 1'b1;
        cyc(18);
        check("repress_t18", pass, 1'b0);
        cyc(1);
        check("repress_t19", pass, 1'b1);

        // Test 6: press again 2 cycles after a grant
        btn = 1'b0; R = 1'b1;
        cyc(2);
        R = 1'b0; G = 1'b1;
        cyc(1);
        check("grant2_pass", pass, 1'b0);
        G = 1'b0;
        cyc(2);
        btn = 1'b1;
        cyc(18);
        check("t6_t18", pass, 1'b0);
        cyc(1);
        check("t6_t19", pass, 1'b1);
        btn = 1'b0;
        cyc(3);

        // Randomized activity
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                btn  = ~btn;
                hold = btn ? $urandom_range(1, 40) : $urandom_range(1, 12);
            end
            hold--;
            R = ($urandom_range(0, 15) == 0);
            Y = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 7) == 0) G = ~G;
            rst = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
